// File: rtl/rvc_fetch_aligner_if.sv
// Fetch/align bus bundle: instruction-memory request/response, decode handshake and redirect.
// The aligner drives through the master modport; the memory/decode side uses slave.
interface rvc_fetch_aligner_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_is_c;
    logic        redirect;
    logic [31:0] redirect_pc;

    modport master (
        output mem_req, mem_addr, instr_valid, instr, instr_pc, instr_is_c,
        input  mem_rdata, instr_ready, redirect, redirect_pc
    );

    modport slave (
        input  mem_req, mem_addr, instr_valid, instr, instr_pc, instr_is_c,
        output mem_rdata, instr_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/rvc_fetch_aligner.sv
// RV32IC fetch aligner: word fetches into a 4-halfword buffer, one 16/32-bit instruction per handshake.
// Define RVC_EN for compressed support; without it every instruction is treated as 32-bit.
module rvc_fetch_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    rvc_fetch_aligner_if.master   bus
);

`ifdef RVC_EN
    localparam logic RVC = 1'b1;
`else
    localparam logic RVC = 1'b0;
`endif

    logic [63:0] buf_r;
    logic [2:0]  hw_cnt_r;
    logic [31:0] buf_pc_r;
    logic [31:0] fetch_pc_r;
    logic        drop_lo_r;
    logic        resp_pend_r;
    logic        resp_drop_r;

    logic [15:0] hw0_s;
    logic [15:0] hw1_s;
    logic        is_c_s;
    logic        valid_s;
    logic        fire_s;
    logic [2:0]  consumed_s;
    logic [2:0]  resp_hw_s;
    logic [2:0]  cnt_after_s;
    logic [2:0]  level_s;
    logic        req_s;
    logic [15:0] app_lo_s;
    logic [63:0] shifted_s;
    logic [63:0] buf_nx_s;
    logic [31:0] redir_buf_pc_s;
    logic [31:0] redir_fetch_pc_s;

    // Instruction decode of the oldest halfword and the fetch throttle
    always_comb begin
        hw0_s       = buf_r[15:0];
        hw1_s       = buf_r[31:16];
        is_c_s      = RVC && (hw0_s[1:0] != 2'b11);
        valid_s     = is_c_s ? (hw_cnt_r >= 3'd1) : (hw_cnt_r >= 3'd2);
        fire_s      = valid_s && bus.instr_ready;
        consumed_s  = fire_s ? (is_c_s ? 3'd1 : 3'd2) : 3'd0;
        resp_hw_s   = resp_pend_r ? (resp_drop_r ? 3'd1 : 3'd2) : 3'd0;
        cnt_after_s = hw_cnt_r - consumed_s;
        level_s     = cnt_after_s + resp_hw_s;
        // rst gates the request so nothing is issued while reset is held
        req_s       = rst && !bus.redirect && (level_s <= 3'd2);
        // redirect_pc[1] only survives into buf_pc when compressed fetch is enabled
        redir_buf_pc_s   = bus.redirect_pc & {30'h3FFF_FFFF, RVC, 1'b0};
        redir_fetch_pc_s = bus.redirect_pc & 32'hFFFF_FFFC;
    end

    // Next buffer contents: shift out consumed halfwords, then append the response
    always_comb begin
        case (consumed_s)
            3'd1:    shifted_s = {16'h0000, buf_r[63:16]};
            3'd2:    shifted_s = {32'h0000_0000, buf_r[63:32]};
            default: shifted_s = buf_r;
        endcase
        app_lo_s = resp_drop_r ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        buf_nx_s = shifted_s;
        for (int i = 0; i < 4; i++) begin
            if ((resp_hw_s != 3'd0) && (3'(i) == cnt_after_s)) begin
                buf_nx_s[16*i +: 16] = app_lo_s;
            end else if ((resp_hw_s == 3'd2) && (3'(i) == cnt_after_s + 3'd1)) begin
                buf_nx_s[16*i +: 16] = bus.mem_rdata[31:16];
            end else begin
                buf_nx_s[16*i +: 16] = shifted_s[16*i +: 16];
            end
        end
    end

    // Buffer, PC and outstanding-request state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_r       <= 64'h0;
            hw_cnt_r    <= 3'd0;
            buf_pc_r    <= RESET_PC;
            fetch_pc_r  <= RESET_PC & 32'hFFFF_FFFC;
            drop_lo_r   <= 1'b0;
            resp_pend_r <= 1'b0;
            resp_drop_r <= 1'b0;
        end else if (bus.redirect) begin
            hw_cnt_r    <= 3'd0;
            buf_pc_r    <= redir_buf_pc_s;
            fetch_pc_r  <= redir_fetch_pc_s;
            drop_lo_r   <= RVC & bus.redirect_pc[1];
            resp_pend_r <= 1'b0;
        end else begin
            buf_r    <= buf_nx_s;
            hw_cnt_r <= level_s;
            buf_pc_r <= buf_pc_r + {28'h0, consumed_s, 1'b0};
            if (req_s) begin
                fetch_pc_r  <= fetch_pc_r + 32'd4;
                resp_pend_r <= 1'b1;
                resp_drop_r <= drop_lo_r;
                drop_lo_r   <= 1'b0;
            end else begin
                resp_pend_r <= 1'b0;
            end
        end
    end

    // Output drive straight from the buffer registers
    always_comb begin
        bus.mem_req     = req_s;
        bus.mem_addr    = fetch_pc_r;
        bus.instr_valid = valid_s;
        bus.instr_pc    = buf_pc_r;
        bus.instr_is_c  = valid_s && is_c_s;
        if (!valid_s) begin
            bus.instr = 32'h0;
        end else if (is_c_s) begin
            bus.instr = {16'h0000, hw0_s};
        end else begin
            bus.instr = {hw1_s, hw0_s};
        end
    end

endmodule
